// File: rtl/oam_dma_ctrl.sv
// Sprite-RAM DMA: copies page $XX00-$XXFF to the PPU OAM port on a CPU write to $4014.
// Define OAM_DMA_ALIGN_EN to insert an ALIGN cycle so every READ lands on parity 0.
module oam_dma_ctrl (
  input  logic        clk,
  input  logic        b_rst,
  input  logic        cpu_wen,
  input  logic [15:0] cpu_addr_out,
  input  logic [7:0]  cpu_data_out,
  input  logic [7:0]  dma_rdata,
  output logic        dma_halt,
  output logic [15:0] dma_addr,
  output logic        dma_ren,
  output logic        dma_wen,
  output logic [7:0]  dma_wdata,
  output logic        dma_done
);

  localparam logic [15:0] OAM_PORT_ADDR = 16'h2004;
  localparam logic [15:0] TRIG_ADDR     = 16'h4014;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  w_idx_nxt;
  logic [7:0]  r_latch;
  logic        r_halt;
  logic        r_ren;
  logic        r_wen;
  logic        r_done;
  logic [15:0] r_addr;
  logic        w_trig;
  logic        w_last;

  assign w_trig = (r_state == S_IDLE) && cpu_wen && (cpu_addr_out == TRIG_ADDR);
  assign w_last = (r_idx == 8'hFF);

`ifdef OAM_DMA_ALIGN_EN
  logic r_parity;

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) r_parity <= 1'b0;
    else        r_parity <= ~r_parity;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_state_nxt = S_HALT;
          w_idx_nxt   = '0;
        end
      end
      S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        // parity flips each cycle: HALT at parity 0 means the next cycle is odd
        w_state_nxt = r_parity ? S_READ : S_ALIGN;
`else
        w_state_nxt = S_READ;
`endif
      end
      S_ALIGN: w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_READ;
          w_idx_nxt   = r_idx + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are valid for the whole cycle.
  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      r_state <= S_IDLE;
      r_page  <= '0;
      r_idx   <= '0;
      r_latch <= '0;
      r_halt  <= 1'b0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_trig)
        r_page <= cpu_data_out;
      if (r_state == S_READ)
        r_latch <= dma_rdata;
      r_halt <= (w_state_nxt != S_IDLE);
      r_ren  <= (w_state_nxt == S_READ);
      r_wen  <= (w_state_nxt == S_WRITE);
      r_done <= (r_state == S_WRITE) && w_last;
      case (w_state_nxt)
        S_READ:  r_addr <= {r_page, w_idx_nxt};
        S_WRITE: r_addr <= OAM_PORT_ADDR;
        default: r_addr <= '0;
      endcase
    end
  end

  assign dma_halt  = r_halt;
  assign dma_addr  = r_addr;
  assign dma_ren   = r_ren;
  assign dma_wen   = r_wen;
  assign dma_wdata = r_latch;
  assign dma_done  = r_done;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: zero-latency memory model, bus monitor, per-transfer checks.
// Expected halted lengths depend on whether OAM_DMA_ALIGN_EN is defined.
module tb_oam_dma_ctrl;

  logic        clk;
  logic        b_rst;
  logic        cpu_wen;
  logic [15:0] cpu_addr_out;
  logic [7:0]  cpu_data_out;
  logic [7:0]  dma_rdata;
  logic        dma_halt;
  logic [15:0] dma_addr;
  logic        dma_ren;
  logic        dma_wen;
  logic [7:0]  dma_wdata;
  logic        dma_done;

  oam_dma_ctrl u_dut (
    .clk          (clk),
    .b_rst        (b_rst),
    .cpu_wen      (cpu_wen),
    .cpu_addr_out (cpu_addr_out),
    .cpu_data_out (cpu_data_out),
    .dma_rdata    (dma_rdata),
    .dma_halt     (dma_halt),
    .dma_addr     (dma_addr),
    .dma_ren      (dma_ren),
    .dma_wen      (dma_wen),
    .dma_wdata    (dma_wdata),
    .dma_done     (dma_done)
  );

`ifdef OAM_DMA_ALIGN_EN
  localparam int HALT_ODD = 514;
`else
  localparam int HALT_ODD = 513;
`endif
  localparam int HALT_EVEN = 513;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign dma_rdata = mem[dma_addr];

  // Reference parity: zero in reset, toggles on every rising edge afterwards.
  logic tb_par;
  always @(posedge clk or negedge b_rst) begin
    if (!b_rst) tb_par <= 1'b0;
    else        tb_par <= ~tb_par;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  logic        mon_clr = 1'b0;
  int          n_rd, n_wr, halt_cnt, done_cnt, done_halt, overlap, odd_rd, idle_strb, bad_waddr;
  logic [15:0] rd_addr [0:255];
  logic [7:0]  wr_data [0:255];

  always @(negedge clk) begin
    if (mon_clr) begin
      n_rd = 0; n_wr = 0; halt_cnt = 0; done_cnt = 0; done_halt = 0;
      overlap = 0; odd_rd = 0; idle_strb = 0; bad_waddr = 0;
    end else begin
      if (dma_halt) halt_cnt++;
      if (dma_ren && dma_wen) overlap++;
      if (!dma_halt && (dma_ren || dma_wen)) idle_strb++;
      if (dma_ren) begin
        if (n_rd < 256) rd_addr[n_rd] = dma_addr;
        n_rd++;
        if (tb_par) odd_rd++;
      end
      if (dma_wen) begin
        if (n_wr < 256) wr_data[n_wr] = dma_wdata;
        n_wr++;
        if (dma_addr != 16'h2004) bad_waddr++;
      end
      if (dma_done) begin
        done_cnt++;
        if (dma_halt) done_halt++;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input logic [7:0] pg, input logic [7:0] idx);
    if (pg == 8'h02) return idx;
    if (pg == 8'h05) return ~idx;
    if (idx == 8'hFC) return 8'h00;
    if (idx == 8'hFD) return 8'h80;
    return idx ^ 8'h3C;
  endfunction

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_wen = 1'b1; cpu_addr_out = a; cpu_data_out = d;
    @(posedge clk);
    #1 cpu_wen = 1'b0; cpu_addr_out = 16'h0000; cpu_data_out = 8'h00;
  endtask

  task automatic trig(input string pre, input logic [7:0] pg, input logic want_par);
    bit hit;
    hit = 0;
    for (int k = 0; k < 4 && !hit; k++) begin
      @(negedge clk);
      if (tb_par == want_par) hit = 1;
    end
    chk({pre, "_par_sync"}, 32'(hit), 32'd1);
    cpu_write(16'h4014, pg);
  endtask

  task automatic wait_done(input string pre);
    bit seen;
    seen = 0;
    for (int k = 0; k < 1200 && !seen; k++) begin
      @(negedge clk);
      if (dma_done) seen = 1;
    end
    chk({pre, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rd(input string pre, input logic [15:0] a);
    bit seen;
    seen = 0;
    for (int k = 0; k < 1200 && !seen; k++) begin
      @(negedge clk);
      if (dma_ren && dma_addr == a) seen = 1;
    end
    chk({pre, "_rd_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic verify_copy(input string pre, input logic [7:0] pg, input int exp_halt);
    int bad_r, bad_d;
    bad_r = 0; bad_d = 0;
    for (int i = 0; i < 256; i++) begin
      if (rd_addr[i] !== {pg, 8'(i)}) bad_r++;
      if (wr_data[i] !== exp_byte(pg, 8'(i))) bad_d++;
    end
    chk({pre, "_n_rd"},      32'(n_rd), 32'd256);
    chk({pre, "_n_wr"},      32'(n_wr), 32'd256);
    chk({pre, "_rd_first"},  32'(rd_addr[0]), 32'({pg, 8'h00}));
    chk({pre, "_rd_last"},   32'(rd_addr[255]), 32'({pg, 8'hFF}));
    chk({pre, "_rd_seq"},    32'(bad_r), 32'd0);
    chk({pre, "_wr_data"},   32'(bad_d), 32'd0);
    chk({pre, "_wr_addr"},   32'(bad_waddr), 32'd0);
    chk({pre, "_halt_len"},  32'(halt_cnt), 32'(exp_halt));
    chk({pre, "_done_cnt"},  32'(done_cnt), 32'd1);
    chk({pre, "_done_halt"}, 32'(done_halt), 32'd0);
    chk({pre, "_overlap"},   32'(overlap), 32'd0);
    chk({pre, "_idle_strb"}, 32'(idle_strb), 32'd0);
    chk({pre, "_halt_end"},  32'(dma_halt), 32'd0);
`ifdef OAM_DMA_ALIGN_EN
    chk({pre, "_odd_rd"},    32'(odd_rd), 32'd0);
`endif
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'hEE;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i);
      mem[16'h0500 + i] = ~8'(i);
      mem[16'hFF00 + i] = 8'(i) ^ 8'h3C;
    end
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;

    b_rst = 1'b0; cpu_wen = 1'b0; cpu_addr_out = '0; cpu_data_out = '0;
    #3;
    chk("rst_halt",  32'(dma_halt),  32'd0);
    chk("rst_ren",   32'(dma_ren),   32'd0);
    chk("rst_wen",   32'(dma_wen),   32'd0);
    chk("rst_addr",  32'(dma_addr),  32'd0);
    chk("rst_wdata", 32'(dma_wdata), 32'd0);
    chk("rst_done",  32'(dma_done),  32'd0);
    repeat (2) @(negedge clk);
    b_rst = 1'b1;

    // Writes to neighbouring registers must not start a transfer.
    @(negedge clk);
    cpu_write(16'h4015, 8'h02);
    cpu_write(16'h4004, 8'h02);
    repeat (3) @(negedge clk);
    chk("notrig_halt", 32'(dma_halt), 32'd0);

    // Basic copy with the cycle after HALT odd, then again with it even.
    mon_clear();
    trig("b1", 8'h02, 1'b1);
    wait_done("b1");
    verify_copy("b1", 8'h02, HALT_ODD);

    mon_clear();
    trig("b0", 8'h02, 1'b0);
    wait_done("b0");
    verify_copy("b0", 8'h02, HALT_EVEN);

    // Retrigger to page $05 mid-transfer is ignored.
    mon_clear();
    trig("rt", 8'h02, 1'b0);
    wait_rd("rt", 16'h0240);
    cpu_write(16'h4014, 8'h05);
    wait_done("rt");
    verify_copy("rt", 8'h02, HALT_EVEN);

    // Asynchronous reset mid-transfer.
    mon_clear();
    trig("rs", 8'h02, 1'b0);
    wait_rd("rs", 16'h0280);
    #2 b_rst = 1'b0;
    #1;
    chk("rs_halt", 32'(dma_halt), 32'd0);
    chk("rs_ren",  32'(dma_ren),  32'd0);
    chk("rs_wen",  32'(dma_wen),  32'd0);
    repeat (3) @(negedge clk);
    chk("rs_done_cnt", 32'(done_cnt), 32'd0);
    chk("rs_addr",     32'(dma_addr), 32'd0);
    b_rst = 1'b1;
    mon_clear();
    trig("rs2", 8'h02, 1'b0);
    wait_done("rs2");
    verify_copy("rs2", 8'h02, HALT_EVEN);

    // Page $FF, including the reset vector bytes.
    mon_clear();
    trig("ff", 8'hFF, 1'b1);
    wait_done("ff");
    verify_copy("ff", 8'hFF, HALT_ODD);
    chk("ff_vec_lo", 32'(wr_data[8'hFC]), 32'h00);
    chk("ff_vec_hi", 32'(wr_data[8'hFD]), 32'h80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
